// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG command master.
// The command entry layout is what the FIFO stores, one entry per accepted command.
package psg_pkg;

    localparam int         PSG_REGS      = 16;
    localparam logic [3:0] PSG_ENV_SHAPE = 4'hD;
    localparam int         CMD_W         = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RWAIT,
        ST_RCAP
    } psg_state_e;

    typedef struct packed {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
    } psg_cmd_t;

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO. Push and pop may happen in the same cycle, even when full.
// ready_o is a registered not-full flag: it is low during reset.
module psg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    used_d;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             ready_q;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full || do_pop);
    assign wr_ptr_d = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
    assign used_d   = wr_ptr_d - rd_ptr_d;
    assign dout_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign ready_o  = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= (used_d != PW'(DEPTH));
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/psg_cmd_master.sv
// Valid/ready command stream to PSG register-bus master with a 16-entry shadow copy.
// Bus strobes are registered from the next state so cs_n/wr_n are glitch-free.
module psg_cmd_master
    import psg_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int STROBE   = 2,
    parameter int SKIP_DUP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [3:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [3:0] psg_addr,
    output logic [7:0] psg_din,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    input  logic [7:0] psg_dout,
    input  logic [3:0] shadow_sel,
    output logic [7:0] shadow_q
);

    localparam int CW = $clog2(STROBE + 1);

    psg_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic             cs_n_q, wr_n_q;
    logic             rsp_valid_q;
    logic [3:0]       rsp_addr_q;
    logic [7:0]       rsp_data_q;
    logic [7:0]       shadow_mem_q [PSG_REGS];

    logic [CMD_W-1:0] head_raw;
    psg_cmd_t         head;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             dup;

    psg_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .din_i   ({cmd_rd, cmd_addr, cmd_data}),
        .pop_i   (fifo_pop),
        .dout_o  (head_raw),
        .empty_o (fifo_empty),
        .ready_o (cmd_ready)
    );

    assign head = psg_cmd_t'(head_raw);

    // Envelope shape writes always go out: each one restarts the envelope.
    assign dup = !head.rd && (SKIP_DUP != 0) && (head.addr != PSG_ENV_SHAPE)
                 && (head.data == shadow_mem_q[head.addr]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        din_d    = din_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rd_d     = head.rd;
                    addr_d   = head.addr;
                    din_d    = head.data;
                    if (!dup) state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = rd_q ? ST_RWAIT : ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == CW'(STROBE - 1)) state_d = ST_HOLD;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            ST_HOLD:  state_d = ST_IDLE;
            ST_RWAIT: state_d = ST_RCAP;
            ST_RCAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < PSG_REGS; i++) shadow_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            cs_n_q      <= !(state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_RWAIT);
            wr_n_q      <= (state_d != ST_STROBE);
            rsp_valid_q <= (state_q == ST_RCAP);
            if (state_q == ST_RCAP) begin
                rsp_data_q <= psg_dout;
                rsp_addr_q <= addr_q;
            end
            // Commit to the shadow once, on the first strobe cycle.
            if (state_q == ST_STROBE && cnt_q == '0) begin
                shadow_mem_q[addr_q] <= din_q;
            end
        end
    end

    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign psg_addr  = addr_q;
    assign psg_din   = din_q;
    assign psg_cs_n  = cs_n_q;
    assign psg_wr_n  = wr_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign shadow_q  = shadow_mem_q[shadow_sel];

endmodule
